// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the RV32I shared-memory datapath.
// Sequences fetch/decode/execute/memory/writeback, traps illegal opcodes, counts retirements.
module multicycle_control #(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter bit          ENABLE_JUMP   = 1'b1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [6:0]       Opcode,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [1:0]       MemToReg,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstRet,
    output logic [3:0]       StateOut
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_JALR   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               illegal_q, illegal_d;
    logic               retire;
    logic               rdy;

    assign rdy = MEM_HANDSHAKE ? MemReady : 1'b1;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (Opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = ENABLE_JUMP ? S_JAL : S_TRAP;
                    OP_JALR:           state_d = ENABLE_JUMP ? S_JALR : S_TRAP;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (Opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (rdy) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                if (rdy) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JAL, S_JALR: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    // Moore decode of the state register; only FETCH's PC/IR writes follow rdy.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        MemToReg    = 2'b00;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = rdy;
                IRWrite = rdy;
            end
            S_DECODE: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 2'b01;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA = 2'b01;
                ALUOp   = 2'b10;
            end
            S_EXEC_I: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA     = 2'b01;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JAL: begin
                PCWrite  = 1'b1;
                PCSource = 2'b01;
                RegWrite = 1'b1;
                MemToReg = 2'b10;
            end
            S_JALR: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                RegWrite = 1'b1;
                MemToReg = 2'b10;
            end
            default: ;
        endcase
        // Reset abandons any in-flight access: no enable may fire this cycle.
        if (Reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
        end
    end

    assign StateOut = state_q;
    assign InstRet  = instret_q;
    assign Illegal  = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: per-instruction phase traces built from
// opcode class and wait counts, checked cycle by cycle against a per-phase output table.
module tb_multicycle_control;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                   P_MEMWR = 5, P_EXEC_R = 6, P_EXEC_I = 7, P_ALUWB = 8, P_BRANCH = 9,
                   P_JAL = 10, P_JALR = 11, P_TRAP = 12;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BAD = 7'b1111111;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       MemReady;
    logic [6:0] Opcode;

    // index 0: defaults, 1: no jumps + 4-bit counter, 2: no memory handshake
    logic [2:0]  pcw, pcwc, irw, rw, mr, mw, iord, ill;
    logic [1:0]  srca [3];
    logic [1:0]  srcb [3];
    logic [1:0]  aluop [3];
    logic [1:0]  pcsrc [3];
    logic [1:0]  m2r [3];
    logic [3:0]  st [3];
    logic [31:0] ir_a, ir_c;
    logic [3:0]  ir_b;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned model_cnt;
    bit          model_ill;

    always #5 Clock = ~Clock;

    multicycle_control u_a (
        .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(pcw[0]), .PCWriteCond(pcwc[0]), .IRWrite(irw[0]), .RegWrite(rw[0]),
        .MemRead(mr[0]), .MemWrite(mw[0]), .IorD(iord[0]), .ALUSrcA(srca[0]),
        .ALUSrcB(srcb[0]), .ALUOp(aluop[0]), .PCSource(pcsrc[0]), .MemToReg(m2r[0]),
        .Illegal(ill[0]), .InstRet(ir_a), .StateOut(st[0])
    );

    multicycle_control #(.ENABLE_JUMP(1'b0), .CNT_W(4)) u_b (
        .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(pcw[1]), .PCWriteCond(pcwc[1]), .IRWrite(irw[1]), .RegWrite(rw[1]),
        .MemRead(mr[1]), .MemWrite(mw[1]), .IorD(iord[1]), .ALUSrcA(srca[1]),
        .ALUSrcB(srcb[1]), .ALUOp(aluop[1]), .PCSource(pcsrc[1]), .MemToReg(m2r[1]),
        .Illegal(ill[1]), .InstRet(ir_b), .StateOut(st[1])
    );

    multicycle_control #(.MEM_HANDSHAKE(1'b0)) u_c (
        .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(pcw[2]), .PCWriteCond(pcwc[2]), .IRWrite(irw[2]), .RegWrite(rw[2]),
        .MemRead(mr[2]), .MemWrite(mw[2]), .IorD(iord[2]), .ALUSrcA(srca[2]),
        .ALUSrcB(srcb[2]), .ALUOp(aluop[2]), .PCSource(pcsrc[2]), .MemToReg(m2r[2]),
        .Illegal(ill[2]), .InstRet(ir_c), .StateOut(st[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [16:0] ctrl(input int k);
        return {pcw[k], pcwc[k], irw[k], rw[k], mr[k], mw[k], iord[k],
                srca[k], srcb[k], aluop[k], pcsrc[k], m2r[k]};
    endfunction

    function automatic logic [5:0] enables(input int k);
        return {pcw[k], pcwc[k], irw[k], rw[k], mr[k], mw[k]};
    endfunction

    // Output table per phase, straight from the control description.
    function automatic logic [16:0] ref_ctrl(input int ph, input bit r);
        logic pw, pwc, iw, rwr, mrd, mwr, iod;
        logic [1:0] a, b, op, ps, mt;
        {pw, pwc, iw, rwr, mrd, mwr, iod} = '0;
        {a, b, op, ps, mt} = '0;
        case (ph)
            P_FETCH:  begin mrd = 1; pw = r; iw = r; b = 2'b01; end
            P_DECODE: begin a = 2'b10; b = 2'b10; end
            P_MEMADR: begin a = 2'b01; b = 2'b10; end
            P_MEMRD:  begin mrd = 1; iod = 1; end
            P_MEMWB:  begin rwr = 1; mt = 2'b01; end
            P_MEMWR:  begin mwr = 1; iod = 1; end
            P_EXEC_R: begin a = 2'b01; op = 2'b10; end
            P_EXEC_I: begin a = 2'b01; b = 2'b10; op = 2'b11; end
            P_ALUWB:  begin rwr = 1; end
            P_BRANCH: begin a = 2'b01; op = 2'b01; pwc = 1; ps = 2'b01; end
            P_JAL:    begin pw = 1; ps = 2'b01; rwr = 1; mt = 2'b10; end
            P_JALR:   begin a = 2'b01; b = 2'b10; pw = 1; ps = 2'b10; rwr = 1; mt = 2'b10; end
            default:  ;
        endcase
        return {pw, pwc, iw, rwr, mrd, mwr, iod, a, b, op, ps, mt};
    endfunction

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge Clock); #1;
            Reset    = 1'b1;
            MemReady = 1'($urandom);
            Opcode   = 7'($urandom);
            @(negedge Clock);
            check("rst_en_a", 32'(enables(0)), 0);
            check("rst_en_b", 32'(enables(1)), 0);
            check("rst_en_c", 32'(enables(2)), 0);
            if (i == 1) begin
                check("rst_state", 32'(st[0]), P_FETCH);
                check("rst_instret", ir_a, 0);
                check("rst_illegal", 32'(ill[0]), 0);
                check("rst_state_b", 32'(st[1]), P_FETCH);
                check("rst_illegal_b", 32'(ill[1]), 0);
            end
        end
        model_cnt = 0;
        model_ill = 1'b0;
    endtask

    // fw/mw: cycles MemReady stays low in FETCH / in the memory access state.
    task automatic run_instr(input logic [6:0] op, input int unsigned fw, input int unsigned mw);
        int ph_q[$];
        bit rdy_q[$];
        int mem_ph;
        for (int unsigned i = 0; i <= fw; i++) begin ph_q.push_back(P_FETCH); rdy_q.push_back(i == fw); end
        ph_q.push_back(P_DECODE); rdy_q.push_back(1'($urandom));
        mem_ph = -1;
        case (op)
            OP_LOAD:  begin ph_q.push_back(P_MEMADR); rdy_q.push_back(1'($urandom)); mem_ph = P_MEMRD; end
            OP_STORE: begin ph_q.push_back(P_MEMADR); rdy_q.push_back(1'($urandom)); mem_ph = P_MEMWR; end
            OP_R:     begin ph_q.push_back(P_EXEC_R); ph_q.push_back(P_ALUWB); end
            OP_I:     begin ph_q.push_back(P_EXEC_I); ph_q.push_back(P_ALUWB); end
            OP_BR:    ph_q.push_back(P_BRANCH);
            OP_JAL:   ph_q.push_back(P_JAL);
            OP_JALR:  ph_q.push_back(P_JALR);
            default:  ph_q.push_back(P_TRAP);
        endcase
        if (mem_ph >= 0) begin
            for (int unsigned i = 0; i <= mw; i++) begin ph_q.push_back(mem_ph); rdy_q.push_back(i == mw); end
            if (op == OP_LOAD) ph_q.push_back(P_MEMWB);
        end
        while (rdy_q.size() < ph_q.size()) rdy_q.push_back(1'($urandom));
        foreach (ph_q[k]) begin
            @(posedge Clock); #1;
            Reset    = 1'b0;
            MemReady = rdy_q[k];
            Opcode   = op;
            @(negedge Clock);
            if (ph_q[k] == P_TRAP) model_ill = 1'b1;
            check("state", 32'(st[0]), ph_q[k]);
            check("ctrl", 32'(ctrl(0)), 32'(ref_ctrl(ph_q[k], rdy_q[k])));
            check("instret", ir_a, model_cnt);
            check("illegal", 32'(ill[0]), 32'(model_ill));
        end
        if (ph_q[ph_q.size()-1] != P_TRAP) model_cnt++;
    endtask

    task automatic trap_hold(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock); #1;
            MemReady = 1'($urandom);
            Opcode   = 7'($urandom);
            @(negedge Clock);
            check("trap_state", 32'(st[0]), P_TRAP);
            check("trap_ctrl", 32'(ctrl(0)), 0);
            check("trap_illegal", 32'(ill[0]), 1);
            check("trap_instret", ir_a, model_cnt);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops [7];
        int exp_c [5];
        ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR};
        exp_c = '{P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB};
        Reset = 1'b1; MemReady = 1'b0; Opcode = '0;
        model_cnt = 0; model_ill = 1'b0;

        do_reset();
        run_instr(OP_R, 0, 0);
        run_instr(OP_LOAD, 0, 0);
        run_instr(OP_STORE, 0, 0);
        run_instr(OP_BR, 0, 0);
        run_instr(OP_LOAD, 0, 3);
        run_instr(OP_JALR, 0, 0);
        run_instr(OP_STORE, 2, 2);

        for (int n = 0; n < 40; n++)
            run_instr(ops[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 3));

        // 17 retirements on the 4-bit counter wrap to 1
        do_reset();
        for (int n = 0; n < 17; n++) run_instr(OP_R, 0, 0);
        @(posedge Clock); #1; MemReady = 1'b1; @(negedge Clock);
        check("wrap_b", 32'(ir_b), 1);
        check("count_a", ir_a, 17);

        do_reset();
        run_instr(OP_R, 0, 0);
        run_instr(OP_BAD, 1, 0);
        trap_hold(4);

        // jal traps on the jump-disabled instance while the default one retires it
        do_reset();
        run_instr(OP_JAL, 0, 0);
        check("b_jal_state", 32'(st[1]), P_TRAP);
        check("b_jal_illegal", 32'(ill[1]), 1);
        run_instr(OP_R, 0, 0);
        check("b_trap_hold", 32'(st[1]), P_TRAP);
        check("b_instret", 32'(ir_b), 0);
        do_reset();

        // with no handshake a load finishes in 5 cycles despite MemReady low
        for (int i = 0; i < 5; i++) begin
            @(posedge Clock); #1; Reset = 1'b0; MemReady = 1'b0; Opcode = OP_LOAD;
            @(negedge Clock);
            check("nohs_state", 32'(st[2]), exp_c[i]);
            check("hs_stall", 32'(st[0]), P_FETCH);
            check("hs_irwrite", 32'(irw[0]), 0);
        end
        @(posedge Clock); #1; @(negedge Clock);
        check("nohs_state_end", 32'(st[2]), P_FETCH);
        check("nohs_instret", ir_c, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
